// File: rtl/line_fill_responder.sv
// Memory-side line-fill responder: word-addressed store answering 128-bit line reads after a fixed latency.
// Optional next-line prefetch buffer enabled by defining MEMRESP_NEXTLINE_PREFETCH_EN.
module line_fill_responder #(
    parameter int unsigned LineWords     = 4,
    parameter int unsigned MemWords      = 1024,
    parameter int unsigned LatencyCycles = 4
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [31:0]               mem_addr_i,
    input  logic                      mem_read_en_i,
    output logic                      mem_read_valid_o,
    output logic [32*LineWords-1:0]   mem_read_data_o,
    input  logic                      load_en_i,
    input  logic [31:0]               load_addr_i,
    input  logic [31:0]               load_data_i,
    output logic                      busy_o,
    output logic [31:0]               served_count_o
);

    localparam int unsigned AddrW = $clog2(MemWords);
    localparam int unsigned OffW  = $clog2(LineWords);
    localparam int unsigned LineW = AddrW - OffW;
    localparam int unsigned DataW = 32 * LineWords;
    localparam int unsigned CntW  = (LatencyCycles > 1) ? $clog2(LatencyCycles) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e             state_q, state_d;
    logic [27:0]        tag_q, tag_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic [DataW-1:0]   data_q, data_d;
    logic               busy_q, busy_d;
    logic [31:0]        count_q, count_d;

    logic [31:0]        mem_q [MemWords];
    logic [LineW-1:0]   rd_line_c;
    logic [DataW-1:0]   rd_data_c;

    logic unused_c;
    assign unused_c = ^{mem_addr_i[3:0], load_addr_i[1:0], load_addr_i[31:AddrW+2]};

    // Backing store: no reset, contents survive rstn_i.
    always_ff @(posedge clk_i) begin
        if (load_en_i) begin
            mem_q[load_addr_i[AddrW+1:2]] <= load_data_i;
        end
    end

    // Line read port: incoming request in IDLE (zero-wait case), latched line otherwise.
    assign rd_line_c = (state_q == IDLE) ? mem_addr_i[AddrW+1:4] : tag_q[LineW-1:0];

    always_comb begin
        rd_data_c = '0;
        for (int k = 0; k < int'(LineWords); k++) begin
            rd_data_c[k*32 +: 32] = mem_q[{rd_line_c, OffW'(k)}];
        end
    end

`ifdef MEMRESP_NEXTLINE_PREFETCH_EN
    logic               pf_valid_q, pf_valid_d;
    logic [LineW-1:0]   pf_tag_q, pf_tag_d;
    logic [DataW-1:0]   pf_data_q, pf_data_d;
    logic               hit_q, hit_d;
    logic [LineW-1:0]   nxt_line_c;
    logic [DataW-1:0]   nxt_data_c;

    assign nxt_line_c = tag_q[LineW-1:0] + LineW'(1);

    always_comb begin
        nxt_data_c = '0;
        for (int k = 0; k < int'(LineWords); k++) begin
            nxt_data_c[k*32 +: 32] = mem_q[{nxt_line_c, OffW'(k)}];
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        data_d  = '0;
        count_d = count_q;
`ifdef MEMRESP_NEXTLINE_PREFETCH_EN
        pf_valid_d = pf_valid_q;
        pf_tag_d   = pf_tag_q;
        pf_data_d  = pf_data_q;
        hit_d      = hit_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (mem_read_en_i) begin
                    tag_d   = mem_addr_i[31:4];
                    cnt_d   = CntW'(LatencyCycles - 1);
                    state_d = BUSY;
`ifdef MEMRESP_NEXTLINE_PREFETCH_EN
                    // Buffer hit: one wait edge, then respond from the buffer.
                    hit_d = pf_valid_q && (pf_tag_q == mem_addr_i[AddrW+1:4]);
                    if (hit_d) begin
                        cnt_d = '0;
                    end
`endif
                    if (LatencyCycles == 1) begin
                        state_d = RESP;
                        valid_d = 1'b1;
                        data_d  = rd_data_c;
                        count_d = count_q + 32'd1;
                    end
                end
            end
            BUSY: begin
                if (!mem_read_en_i) begin
                    state_d = IDLE;
                end else if (mem_addr_i[31:4] != tag_q) begin
                    tag_d = mem_addr_i[31:4];
                    cnt_d = CntW'(LatencyCycles - 1);
`ifdef MEMRESP_NEXTLINE_PREFETCH_EN
                    hit_d = 1'b0;
`endif
                end else if (cnt_q == '0) begin
                    state_d = RESP;
                    valid_d = 1'b1;
                    data_d  = rd_data_c;
                    count_d = count_q + 32'd1;
`ifdef MEMRESP_NEXTLINE_PREFETCH_EN
                    if (hit_q && pf_valid_q) begin
                        data_d = pf_data_q;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
`ifdef MEMRESP_NEXTLINE_PREFETCH_EN
                pf_tag_d   = nxt_line_c;
                pf_data_d  = nxt_data_c;
                pf_valid_d = 1'b1;
                hit_d      = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
`ifdef MEMRESP_NEXTLINE_PREFETCH_EN
        // Any write into the buffered line (including one landing on the fill edge) invalidates it.
        if (load_en_i && (load_addr_i[AddrW+1:4] == pf_tag_d)) begin
            pf_valid_d = 1'b0;
        end
`endif
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            tag_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
`ifdef MEMRESP_NEXTLINE_PREFETCH_EN
            pf_valid_q <= 1'b0;
            pf_tag_q   <= '0;
            pf_data_q  <= '0;
            hit_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            count_q <= count_d;
`ifdef MEMRESP_NEXTLINE_PREFETCH_EN
            pf_valid_q <= pf_valid_d;
            pf_tag_q   <= pf_tag_d;
            pf_data_q  <= pf_data_d;
            hit_q      <= hit_d;
`endif
        end
    end

    assign mem_read_valid_o = valid_q;
    assign mem_read_data_o  = data_q;
    assign busy_o           = busy_q;
    assign served_count_o   = count_q;

endmodule

// File: tb/tb_line_fill_responder.sv
// Testbench for line_fill_responder: vector table, directed corner cases and a randomized
// run against a timestamp-based transaction model.
module tb_line_fill_responder;

    localparam int unsigned MemWords = 1024;
    localparam int unsigned Lines    = MemWords / 4;
    localparam int          Lat      = 4;
`ifdef MEMRESP_NEXTLINE_PREFETCH_EN
    localparam bit PfEn = 1'b1;
`else
    localparam bit PfEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstn;
    logic [31:0]  addr;
    logic         rd_en;
    logic         valid;
    logic [127:0] data;
    logic         load_en;
    logic [31:0]  load_addr;
    logic [31:0]  load_data;
    logic         busy;
    logic [31:0]  cnt;

    line_fill_responder dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .mem_addr_i       (addr),
        .mem_read_en_i    (rd_en),
        .mem_read_valid_o (valid),
        .mem_read_data_o  (data),
        .load_en_i        (load_en),
        .load_addr_i      (load_addr),
        .load_data_i      (load_data),
        .busy_o           (busy),
        .served_count_o   (cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: store image plus one outstanding request described by timestamps.
    logic [31:0]  st [MemWords];
    int           edge_n = 0;
    bit           m_resp = 1'b0;
    bit           m_pend = 1'b0;
    logic [27:0]  m_tag  = '0;
    int           m_line = 0;
    int           m_acc  = 0;
    int           m_lat  = Lat;
    logic [127:0] m_data = '0;
    logic [31:0]  m_count = '0;
    bit           pf_v   = 1'b0;
    int           pf_line = 0;

    typedef struct {
        logic         re;
        logic [31:0]  a;
        logic         le;
        logic [31:0]  la;
        logic [31:0]  ld;
        logic         ev;
        logic         eb;
        logic [127:0] ed;
        logic [31:0]  ec;
    } vec_t;

    vec_t vecs [19];

    function automatic logic [31:0] pat(input int i);
        return 32'h5A00_0000 + 32'(i) * 32'h0001_0001;
    endfunction

    function automatic logic [127:0] pline(input int l);
        return {pat(l*4+3), pat(l*4+2), pat(l*4+1), pat(l*4)};
    endfunction

    function automatic logic [127:0] mline(input int l);
        return {st[l*4+3], st[l*4+2], st[l*4+1], st[l*4]};
    endfunction

    function automatic vec_t mk(input logic re, input logic [31:0] a, input logic le,
                                input logic [31:0] la, input logic [31:0] ld, input logic ev,
                                input logic eb, input logic [127:0] ed, input logic [31:0] ec);
        vec_t v;
        v.re = re; v.a = a; v.le = le; v.la = la; v.ld = ld;
        v.ev = ev; v.eb = eb; v.ed = ed; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_resp = 1'b0; m_pend = 1'b0; m_data = '0; m_count = '0; pf_v = 1'b0;
    endtask

    task automatic model_edge(input logic re, input logic [31:0] a, input logic le,
                              input logic [31:0] la, input logic [31:0] ld);
        int ln;
        int wi;
        edge_n++;
        ln = int'((a / 16) % Lines);
        if (m_resp) begin
            m_resp  = 1'b0;
            m_data  = '0;
            pf_v    = 1'b1;
            pf_line = (m_line + 1) % int'(Lines);
        end else if (m_pend) begin
            if (!re) begin
                m_pend = 1'b0;
            end else if (a[31:4] != m_tag) begin
                m_tag = a[31:4]; m_line = ln; m_acc = edge_n; m_lat = Lat;
            end else if (edge_n - m_acc == m_lat) begin
                m_data = mline(m_line);
                m_resp = 1'b1;
                m_pend = 1'b0;
                m_count++;
            end
        end else if (re) begin
            m_tag = a[31:4]; m_line = ln; m_acc = edge_n; m_pend = 1'b1;
            m_lat = (PfEn && pf_v && pf_line == ln) ? 1 : Lat;
        end
        if (le) begin
            wi = int'((la / 4) % MemWords);
            st[wi] = ld;
            if (pf_v && (wi / 4) == pf_line) pf_v = 1'b0;
        end
    endtask

    task automatic step(input logic re, input logic [31:0] a, input logic le,
                        input logic [31:0] la, input logic [31:0] ld);
        rd_en = re; addr = a; load_en = le; load_addr = la; load_data = ld;
        @(posedge clk);
        model_edge(re, a, le, la, ld);
        @(negedge clk);
        chk("model_valid", 128'(valid), 128'(m_resp));
        chk("model_data", data, m_data);
        chk("model_busy", 128'(busy), 128'(m_pend | m_resp));
        chk("model_count", 128'(cnt), 128'(m_count));
    endtask

    task automatic hold_req(input logic [31:0] a, output int n, output logic [127:0] d);
        bit got;
        got = 1'b0; n = 0; d = '0;
        while (!got && n < 20) begin
            step(1'b1, a, 1'b0, 32'h0, 32'h0);
            n++;
            if (valid) begin
                got = 1'b1;
                d = data;
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL hold_req_timeout: no valid for addr %0h after %0d cycles", a, n);
        end
    endtask

    initial begin
        int n;
        int pulses;
        int consec;
        logic prev;
        logic [31:0] c0;
        logic [127:0] d;
        logic [31:0] alist [6];
        logic re_r;
        logic [31:0] a_r;
        logic [127:0] la_blk;

        la_blk = {32'hA0A0_0003, 32'hA0A0_0002, 32'hA0A0_0001, 32'hA0A0_0000};
        vecs[0]  = mk(0, 32'h0,   1, 32'h100, 32'hA0A0_0000, 0, 0, '0, 0);
        vecs[1]  = mk(0, 32'h0,   1, 32'h104, 32'hA0A0_0001, 0, 0, '0, 0);
        vecs[2]  = mk(0, 32'h0,   1, 32'h108, 32'hA0A0_0002, 0, 0, '0, 0);
        vecs[3]  = mk(0, 32'h0,   1, 32'h10C, 32'hA0A0_0003, 0, 0, '0, 0);
        vecs[4]  = mk(1, 32'h104, 0, 32'h0, 32'h0, 0, 1, '0, 0);
        vecs[5]  = mk(1, 32'h104, 0, 32'h0, 32'h0, 0, 1, '0, 0);
        vecs[6]  = mk(1, 32'h104, 0, 32'h0, 32'h0, 0, 1, '0, 0);
        vecs[7]  = mk(1, 32'h104, 0, 32'h0, 32'h0, 0, 1, '0, 0);
        vecs[8]  = mk(1, 32'h104, 0, 32'h0, 32'h0, 1, 1, la_blk, 1);
        vecs[9]  = mk(0, 32'h0,   0, 32'h0, 32'h0, 0, 0, '0, 1);
        vecs[10] = mk(1, 32'h200, 0, 32'h0, 32'h0, 0, 1, '0, 1);
        vecs[11] = mk(1, 32'h200, 0, 32'h0, 32'h0, 0, 1, '0, 1);
        vecs[12] = mk(0, 32'h200, 0, 32'h0, 32'h0, 0, 0, '0, 1);
        vecs[13] = mk(1, 32'h200, 0, 32'h0, 32'h0, 0, 1, '0, 1);
        vecs[14] = mk(1, 32'h200, 0, 32'h0, 32'h0, 0, 1, '0, 1);
        vecs[15] = mk(1, 32'h200, 0, 32'h0, 32'h0, 0, 1, '0, 1);
        vecs[16] = mk(1, 32'h200, 0, 32'h0, 32'h0, 0, 1, '0, 1);
        vecs[17] = mk(1, 32'h200, 0, 32'h0, 32'h0, 1, 1, pline(32'h20), 2);
        vecs[18] = mk(0, 32'h0,   0, 32'h0, 32'h0, 0, 0, '0, 2);

        rstn = 1'b0; rd_en = 1'b0; addr = '0; load_en = 1'b0; load_addr = '0; load_data = '0;
        repeat (2) @(negedge clk);
        chk("reset_valid", 128'(valid), 128'(0));
        chk("reset_data", data, 128'(0));
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_count", 128'(cnt), 128'(0));
        rstn = 1'b1;

        for (int i = 0; i < int'(MemWords); i++) begin
            step(1'b0, 32'h0, 1'b1, 32'(i) * 32'd4, pat(i));
        end

        // Basic fill with 4-cycle latency, then abort and normal service.
        for (int i = 0; i < 19; i++) begin
            step(vecs[i].re, vecs[i].a, vecs[i].le, vecs[i].la, vecs[i].ld);
            chk($sformatf("vec%0d_valid", i), 128'(valid), 128'(vecs[i].ev));
            chk($sformatf("vec%0d_busy", i), 128'(busy), 128'(vecs[i].eb));
            chk($sformatf("vec%0d_data", i), data, vecs[i].ed);
            chk($sformatf("vec%0d_count", i), 128'(cnt), 128'(vecs[i].ec));
        end

        // Address change mid-BUSY restarts the latency.
        step(1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
        step(1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
        step(1'b1, 32'h300, 1'b0, 32'h0, 32'h0);
        hold_req(32'h300, n, d);
        chk("t3_latency", 128'(n), 128'(4));
        chk("t3_data", d, pline(32'h30));
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

        // Write at the capture edge: response is read-before-write.
        repeat (4) step(1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
        step(1'b1, 32'h100, 1'b1, 32'h108, 32'hDEAD_BEEF);
        chk("t4_valid", 128'(valid), 128'(1));
        chk("t4_old_data", data, la_blk);
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        hold_req(32'h100, n, d);
        chk("t4_new_word", 128'(d[95:64]), 128'(32'hDEAD_BEEF));
        chk("t4_latency", 128'(n), 128'(5));
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

        // Request held through RESP: isolated pulses, one count per pulse.
        c0 = cnt; pulses = 0; consec = 0; prev = 1'b0;
        for (int i = 0; i < 18; i++) begin
            step(1'b1, 32'h110, 1'b0, 32'h0, 32'h0);
            if (valid) pulses++;
            if (valid && prev) consec++;
            prev = valid;
        end
        chk("t5_no_back2back", 128'(consec), 128'(0));
        chk("t5_pulses", 128'(pulses), 128'(3));
        chk("t5_count_delta", 128'(cnt - c0), 128'(pulses));
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

        // Sequential lines: prefetch hit when enabled; load into buffered line forces full latency.
        hold_req(32'h100, n, d);
        chk("t6_first_latency", 128'(n), 128'(5));
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        hold_req(32'h110, n, d);
        chk("t6_next_latency", 128'(n), 128'(PfEn ? 2 : 5));
        chk("t6_next_data", d, mline(32'h11));
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 32'h124, 32'hCAFE_F00D);
        hold_req(32'h120, n, d);
        chk("t6_patched_latency", 128'(n), 128'(5));
        chk("t6_patched_word", 128'(d[63:32]), 128'(32'hCAFE_F00D));
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

        // Asynchronous reset mid-BUSY and mid-RESP.
        step(1'b1, 32'h200, 1'b0, 32'h0, 32'h0);
        step(1'b1, 32'h200, 1'b0, 32'h0, 32'h0);
        rstn = 1'b0;
        #1;
        chk("rst_busy_busy", 128'(busy), 128'(0));
        chk("rst_busy_count", 128'(cnt), 128'(0));
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        hold_req(32'h200, n, d);
        chk("rst_resp_pre_valid", 128'(valid), 128'(1));
        rstn = 1'b0;
        #1;
        chk("rst_resp_valid", 128'(valid), 128'(0));
        chk("rst_resp_data", data, 128'(0));
        chk("rst_resp_busy", 128'(busy), 128'(0));
        model_reset();
        @(negedge clk);
        rstn = 1'b1;

        // Randomized traffic, including aliased and wrapping addresses.
        alist[0] = 32'h0000_0100; alist[1] = 32'h0000_0110; alist[2] = 32'h0000_0120;
        alist[3] = 32'h0000_3FF0; alist[4] = 32'hFFF0_3FF4; alist[5] = 32'h0000_0008;
        re_r = 1'b0; a_r = alist[0];
        for (int i = 0; i < 800; i++) begin
            logic le_r;
            logic [31:0] la_r;
            if (!re_r) re_r = ($urandom % 3) == 0;
            else       re_r = ($urandom % 10) != 0;
            if (($urandom % 8) == 0) a_r = alist[$urandom % 6];
            le_r = ($urandom % 4) == 0;
            la_r = ($urandom % 2) ? (a_r ^ 32'($urandom % 16)) : $urandom;
            step(re_r, a_r, le_r, la_r, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
